issue_ctrl: RTL and testbench
=============================

ISSUE_CTRL -- requirements
Module: issue_ctrl

Interface
REQ-001 Parameter DEPTH, default 8, instruction queue entries; SHALL be a power of two, at least 4.
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 resetn  input  1  reset, asynchronous and active-low.
REQ-004 flush  input  1  synchronous queue clear (branch mispredict / exception).
REQ-005 w_data_1  input  64  fetch slot 1 entry {pc[63:32], inst[31:0]}.
REQ-006 w_en_1  input  1  push request for slot 1.
REQ-007 w_data_2  input  64  fetch slot 2 entry, same format.
REQ-008 w_en_2  input  1  push request for slot 2; valid only with w_en_1.
REQ-009 full  output  1  fewer than 2 free entries; fetch SHALL hold.
REQ-010 id_stall  input  1  decode cannot accept instructions this cycle.
REQ-011 id_pc_1 / id_inst_1  output  32 / 32  oldest queued entry.
REQ-012 id_en_1  output  1  id_pc_1/id_inst_1 issued this cycle.
REQ-013 id_pc_2 / id_inst_2  output  32 / 32  second-oldest entry.
REQ-014 id_en_2  output  1  id_pc_2/id_inst_2 issued this cycle.
REQ-015 count  output  log2(DEPTH)+1  number of occupied entries.

Function
REQ-016 Queue SHALL be circular: write pointer wptr, read pointer rptr, both log2(DEPTH) bits, wrapping modulo DEPTH.
REQ-017 full SHALL equal (count > DEPTH-2), combinational from count.
REQ-018 Push: when full=0 and w_en_1=1, w_data_1 written at wptr; if also w_en_2=1, w_data_2 written at wptr+1; wptr advances by 1 or 2.
REQ-019 Push with full=1 SHALL be discarded with no state change; w_en_2=1 with w_en_1=0 SHALL be ignored.
REQ-020 id_pc_1/id_inst_1 SHALL show entry at rptr when count>=1, else 0; id_pc_2/id_inst_2 entry at rptr+1 when count>=2, else 0.
REQ-021 id_en_1 = (count>=1) and not id_stall and not flush.
REQ-022 id_en_2 = id_en_1 and (count>=2) and not dep.
REQ-023 Destination of inst1: opcode==0 -> inst[15:11]; opcode[5:3]==3'b001 or 3'b100 -> inst[20:16]; otherwise none (treated as 0).
REQ-024 dep SHALL be 1 when destination != 0 and equals inst2[25:21] or inst2[20:16].
REQ-025 Pop: rptr advances by id_en_1 + id_en_2 at the clock edge.
REQ-026 Simultaneous push and pop: count_next = count + pushed - popped; an entry pushed at edge N SHALL be visible at outputs during cycle N+1 (one-cycle latency, no bypass).
REQ-027 Wrap-around: entries spanning index DEPTH-1 and 0 SHALL issue as a normal pair.
REQ-028 flush=1: at next edge wptr, rptr, count SHALL become 0; same-cycle pushes discarded; id_en_1/id_en_2 forced 0 during the flush cycle.
REQ-029 flush has priority over push, pop and id_stall.
REQ-030 Queue storage need not be reset; outputs are qualified by count.

Reset
REQ-031 resetn=0 SHALL immediately clear wptr, rptr, count; full=0, id_en_1=id_en_2=0, id_pc/id_inst outputs=0.
REQ-032 Reset asserted mid-operation SHALL discard all entries; first push after release lands at index 0.
REQ-033 Pushes during the cycle resetn deasserts SHALL NOT be required to take effect.

Verification
REQ-034 Reset, push {0xBFC00000,0x24080001},{0xBFC00004,0x24090002} -> next cycle id_en_1=1, id_en_2=1, count=2, then count=0.
REQ-035 Push {pc A, addiu $8,$0,1 (0x24080001)}, {pc A+4, addu $10,$8,$9 (0x01095021)} -> cycle 1 id_en_1=1, id_en_2=0; cycle 2 inst 0x01095021 issues as slot 1.
REQ-036 id_stall=1, push 4 pairs with DEPTH=8 -> count=7 or 8 stops at full=1 after count 7; further pushes dropped; release stall drains in pairs, order preserved.
REQ-037 Fill to index 7 then push pair -> wrap to 0; pair straddling index 7/0 issues with both enables=1 and correct pcs.
REQ-038 count=5 with push pair and flush same cycle -> next cycle count=0, id_en_1=0, full=0.
REQ-039 Assert resetn=0 asynchronously mid-cycle with count=6 -> outputs clear before next edge; count=0.

Source files
------------

// File: rtl/issue_if.sv
// issue_if: fetch-to-decode handshake bundle for the dual-issue instruction queue.
interface issue_if #(parameter int DEPTH = 8);
  localparam int CW = $clog2(DEPTH) + 1;
  logic          flush;
  logic [63:0]   w_data_1;
  logic          w_en_1;
  logic [63:0]   w_data_2;
  logic          w_en_2;
  logic          full;
  logic          id_stall;
  logic [31:0]   id_pc_1;
  logic [31:0]   id_inst_1;
  logic          id_en_1;
  logic [31:0]   id_pc_2;
  logic [31:0]   id_inst_2;
  logic          id_en_2;
  logic [CW-1:0] count;
  modport master (
    output flush, w_data_1, w_en_1, w_data_2, w_en_2, id_stall,
    input  full, id_pc_1, id_inst_1, id_en_1, id_pc_2, id_inst_2, id_en_2, count
  );
  modport slave (
    input  flush, w_data_1, w_en_1, w_data_2, w_en_2, id_stall,
    output full, id_pc_1, id_inst_1, id_en_1, id_pc_2, id_inst_2, id_en_2, count
  );
endinterface

// File: rtl/issue_ctrl.sv
// issue_ctrl: circular instruction queue accepting two fetch slots and issuing up to two
// entries per cycle to decode, holding back slot 2 when it reads slot 1's destination.
module issue_ctrl #(parameter int DEPTH = 8) (
  input  logic   clk,
  input  logic   resetn,
  issue_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  logic [63:0]   mem_q [DEPTH];
  logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d, wptr_n1, rptr_n1;
  logic [AW:0]   count_q, count_d, n_push, n_pop;
  logic          full, push_1, push_2, has_1, has_2, dep, en_1, en_2;
  logic [4:0]    dest;
  logic [63:0]   ent_1, ent_2;
  always_comb begin
    wptr_n1 = wptr_q + 1'b1;
    rptr_n1 = rptr_q + 1'b1;
    ent_1   = mem_q[rptr_q];
    ent_2   = mem_q[rptr_n1];
    has_1   = count_q != '0;
    has_2   = count_q > (AW+1)'(1);
    full    = count_q > (AW+1)'(DEPTH - 2);
    push_1  = bus.w_en_1 & ~full & ~bus.flush;
    push_2  = push_1 & bus.w_en_2;
    // R-type writes rd; immediate ALU ops and loads write rt; everything else writes nothing
    dest    = (ent_1[31:26] == 6'd0) ? ent_1[15:11] :
              (ent_1[31:29] == 3'b001 || ent_1[31:29] == 3'b100) ? ent_1[20:16] : 5'd0;
    dep     = (dest != 5'd0) && (dest == ent_2[25:21] || dest == ent_2[20:16]);
    en_1    = has_1 & ~bus.id_stall & ~bus.flush;
    en_2    = en_1 & has_2 & ~dep;
    n_push  = (AW+1)'(push_1) + (AW+1)'(push_2);
    n_pop   = (AW+1)'(en_1) + (AW+1)'(en_2);
    wptr_d  = bus.flush ? '0 : wptr_q + AW'(n_push);
    rptr_d  = bus.flush ? '0 : rptr_q + AW'(n_pop);
    count_d = bus.flush ? '0 : count_q + n_push - n_pop;
  end
  assign bus.full      = full;
  assign bus.count     = count_q;
  assign bus.id_en_1   = en_1;
  assign bus.id_en_2   = en_2;
  assign bus.id_pc_1   = has_1 ? ent_1[63:32] : '0;
  assign bus.id_inst_1 = has_1 ? ent_1[31:0]  : '0;
  assign bus.id_pc_2   = has_2 ? ent_2[63:32] : '0;
  assign bus.id_inst_2 = has_2 ? ent_2[31:0]  : '0;
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end
  always_ff @(posedge clk) begin
    if (push_1) mem_q[wptr_q] <= bus.w_data_1;
    if (push_2) mem_q[wptr_n1] <= bus.w_data_2;
  end
endmodule

// File: tb/tb_issue_ctrl.sv
// tb_issue_ctrl: vector table plus in-order scoreboard for the dual-issue instruction queue.
module tb_issue_ctrl;
  localparam int DEPTH = 8;
  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;
  issue_if #(.DEPTH(DEPTH)) bus();
  issue_ctrl #(.DEPTH(DEPTH)) dut (.clk(clk), .resetn(resetn), .bus(bus.slave));
  typedef struct {
    logic        we1, we2;
    logic [63:0] d1, d2;
    logic        stall, fl;
    logic        e1, e2;
    int          cnt;
    logic        full;
  } vec_t;
  vec_t        tbl[$];
  logic [63:0] sb[$];
  int          checks = 0;
  int          errors = 0;
  task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s got=%h want=%h at %0t", n, a, e, $time);
    end
  endtask
  function automatic logic [63:0] ent(input int k);
    return {32'h1000_0000 + 32'(k) * 32'd4, 6'b000010, 26'(k)};
  endfunction
  function automatic vec_t mk(input logic we1, we2, input logic [63:0] d1, d2,
                              input logic stall, fl, e1, e2, input int cnt, input logic full);
    vec_t v;
    v.we1 = we1; v.we2 = we2; v.d1 = d1; v.d2 = d2; v.stall = stall; v.fl = fl;
    v.e1 = e1; v.e2 = e2; v.cnt = cnt; v.full = full;
    return v;
  endfunction
  task automatic pop_chk(input string n, input logic [63:0] act);
    logic [63:0] x;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s got=%h want=<scoreboard empty>", n, act);
    end else begin
      x = sb.pop_front();
      chk(n, act, x);
    end
  endtask
  task automatic step(input vec_t v);
    bus.w_en_1 = v.we1; bus.w_en_2 = v.we2; bus.w_data_1 = v.d1; bus.w_data_2 = v.d2;
    bus.id_stall = v.stall; bus.flush = v.fl;
    #1;
    chk("count", 64'(bus.count), 64'(v.cnt));
    chk("full", 64'(bus.full), 64'(v.full));
    chk("id_en_1", 64'(bus.id_en_1), 64'(v.e1));
    chk("id_en_2", 64'(bus.id_en_2), 64'(v.e2));
    if (v.cnt == 0) chk("slot1_zero", {bus.id_pc_1, bus.id_inst_1}, 64'd0);
    if (v.cnt < 2) chk("slot2_zero", {bus.id_pc_2, bus.id_inst_2}, 64'd0);
    if (v.e1) pop_chk("slot1", {bus.id_pc_1, bus.id_inst_1});
    if (v.e2) pop_chk("slot2", {bus.id_pc_2, bus.id_inst_2});
    if (v.fl) sb.delete();
    else if (v.we1 && !v.full) begin
      sb.push_back(v.d1);
      if (v.we2) sb.push_back(v.d2);
    end
    @(posedge clk);
    #1;
  endtask
  task automatic chk_cleared(input string n);
    chk({n, "_count"}, 64'(bus.count), 64'd0);
    chk({n, "_full"}, 64'(bus.full), 64'd0);
    chk({n, "_en"}, {62'd0, bus.id_en_1, bus.id_en_2}, 64'd0);
    chk({n, "_slot1"}, {bus.id_pc_1, bus.id_inst_1}, 64'd0);
    chk({n, "_slot2"}, {bus.id_pc_2, bus.id_inst_2}, 64'd0);
  endtask
  initial begin
    #100000;
    $display("FAIL timeout got=running want=finished");
    $fatal(1, "timeout");
  end
  initial begin
    logic [63:0] z = 64'd0;
    bus.flush = 0; bus.w_en_1 = 0; bus.w_en_2 = 0; bus.id_stall = 0;
    bus.w_data_1 = '0; bus.w_data_2 = '0;
    // we1 we2 d1 d2 stall flush | e1 e2 count full
    tbl.push_back(mk(1, 1, 64'hBFC00000_24080001, 64'hBFC00004_24090002, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, z, z, 0, 0, 1, 1, 2, 0));
    tbl.push_back(mk(0, 0, z, z, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 1, 64'h00400000_24080001, 64'h00400004_01095021, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, z, z, 0, 0, 1, 0, 2, 0));
    tbl.push_back(mk(0, 0, z, z, 0, 0, 1, 0, 1, 0));
    tbl.push_back(mk(0, 0, z, z, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 1, ent(0), ent(1), 1, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 1, ent(2), ent(3), 1, 0, 0, 0, 2, 0));
    tbl.push_back(mk(0, 1, z, ent(99), 1, 0, 0, 0, 4, 0));
    tbl.push_back(mk(1, 1, ent(4), ent(5), 1, 0, 0, 0, 4, 0));
    tbl.push_back(mk(1, 0, ent(6), z, 1, 0, 0, 0, 6, 0));
    tbl.push_back(mk(1, 1, ent(7), ent(8), 1, 0, 0, 0, 7, 1));
    tbl.push_back(mk(0, 0, z, z, 0, 0, 1, 1, 7, 1));
    tbl.push_back(mk(0, 0, z, z, 0, 0, 1, 1, 5, 0));
    tbl.push_back(mk(0, 0, z, z, 0, 0, 1, 1, 3, 0));
    tbl.push_back(mk(0, 0, z, z, 0, 0, 1, 0, 1, 0));
    tbl.push_back(mk(0, 0, z, z, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 1, ent(20), ent(21), 1, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 1, ent(22), ent(23), 1, 0, 0, 0, 2, 0));
    tbl.push_back(mk(1, 1, ent(24), ent(25), 1, 0, 0, 0, 4, 0));
    tbl.push_back(mk(1, 1, ent(26), ent(27), 0, 0, 1, 1, 6, 0));
    tbl.push_back(mk(0, 0, z, z, 0, 0, 1, 1, 6, 0));
    tbl.push_back(mk(0, 0, z, z, 0, 0, 1, 1, 4, 0));
    tbl.push_back(mk(0, 0, z, z, 0, 0, 1, 1, 2, 0));
    tbl.push_back(mk(0, 0, z, z, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 1, ent(40), ent(41), 1, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 1, ent(42), ent(43), 1, 0, 0, 0, 2, 0));
    tbl.push_back(mk(1, 0, ent(44), z, 1, 0, 0, 0, 4, 0));
    tbl.push_back(mk(1, 1, ent(45), ent(46), 0, 1, 0, 0, 5, 0));
    tbl.push_back(mk(0, 0, z, z, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 1, ent(60), ent(61), 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, z, z, 0, 0, 1, 1, 2, 0));
    tbl.push_back(mk(0, 0, z, z, 0, 0, 0, 0, 0, 0));
    #12;
    chk_cleared("reset");
    @(negedge clk);
    resetn = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < tbl.size(); i++) step(tbl[i]);
    chk("drained", 64'(sb.size()), 64'd0);
    // async reset in the middle of a cycle with six entries queued
    step(mk(1, 1, ent(70), ent(71), 1, 0, 0, 0, 0, 0));
    step(mk(1, 1, ent(72), ent(73), 1, 0, 0, 0, 2, 0));
    step(mk(1, 1, ent(74), ent(75), 1, 0, 0, 0, 4, 0));
    bus.w_en_1 = 0; bus.w_en_2 = 0; bus.id_stall = 1;
    #1;
    chk("pre_reset_count", 64'(bus.count), 64'd6);
    #2;
    resetn = 1'b0;
    #1;
    chk_cleared("async_reset");
    sb.delete();
    #2;
    resetn = 1'b1;
    @(posedge clk);
    #1;
    step(mk(1, 1, ent(80), ent(81), 0, 0, 0, 0, 0, 0));
    chk("post_reset_idx0", dut.mem_q[0], ent(80));
    chk("post_reset_idx1", dut.mem_q[1], ent(81));
    step(mk(0, 0, z, z, 0, 0, 1, 1, 2, 0));
    step(mk(0, 0, z, z, 0, 0, 0, 0, 0, 0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
